multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle sequencer for the LEGv8 datapath (ALU, register file, sign-extender, instruction/data memories). It replaces per-instruction static decode with a per-phase FSM.
- Drives the same datapath control fields (reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, branch, uncond_branch, aluop, signop) only in the phase where each field matters.
- Adds instruction-register load, PC write and PC-source select.
- Handshakes with variable-latency instruction and data memories, with a bounded wait timeout.

Parameters:
WAIT_LIMIT, 255, max cycles any memory wait may last before fault; 0 disables timeout
CNT_W, 8, width of wait counter; must hold WAIT_LIMIT

Ports:
CLK  in  1  clock, all state on rising edge
resetl  in  1  asynchronous active-low reset
ir_opcode  in  11  instruction[31:21] from instruction register (valid from DECODE on)
alu_zero  in  1  ALU zero flag, combinational in EXEC
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory read data valid / write accepted this cycle
imem_req  out  1  fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = branch target
reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, branch, uncond_branch  out  1 each  datapath controls
aluop  out  4  ALU operation
signop  out  2  sign-extend mode
instr_done  out  1  one-cycle pulse on retire
halted  out  1  sticky; illegal opcode or timeout
fault_code  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout

Behaviour:
- Reset (resetl low, async): state=FETCH, wait counter=0, fault_code=00. Every output is 0 while in reset and until driven by a state. All "don't care" fields are driven 0, never x.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1.
  - imem_ready=1: ir_write=1 → DECODE.
  - Otherwise stay, counter++.
- DECODE: one cycle; classify ir_opcode (casez). Illegal → HALT with fault 01. Else → EXEC.
- EXEC: drive reg2loc/alusrc/aluop/signop per class.
  - AND 0000, ORR 0001, ADD/ADDI/LDUR/STUR 0010, SUB/SUBI 0110, CBZ pass-B 0111, MOVZ 1000.
  - signop: I-type 00, CBZ 01, B 10, D-type 11.
  - B: uncond_branch=1, pc_src=1, pc_write=1, instr_done=1 → FETCH.
  - CBZ: branch=1, reg2loc=1; pc_src=alu_zero, pc_write=1, instr_done=1 → FETCH.
  - LDUR/STUR → MEM.
  - R/I/MOVZ → WB.
- MEM: alusrc=1, aluop=0010, signop=11 held stable; reg2loc=1 for STUR.
  - LDUR: memread=1. On dmem_ready → WB.
  - STUR: memwrite=1. On dmem_ready: pc_write=1, pc_src=0, instr_done=1 → FETCH.
  - Otherwise stay, counter++.
- WB: regwrite=1, mem2reg=1 for LDUR else 0; EXEC fields held. pc_write=1, pc_src=0, instr_done=1 → FETCH.
- Latency with zero-wait memories (ready same cycle as request):
  - B/CBZ 3 cycles.
  - R/I/MOVZ/STUR 4 cycles.
  - LDUR 5 cycles.
- Wait counter:
  - Cleared on every state transition.
  - Saturates; when it equals WAIT_LIMIT (nonzero) with ready still low → HALT with fault 10 (FETCH) or 11 (MEM).
  - Ready in the same cycle the limit is reached wins; no fault.
- HALT: all controls 0, halted=1, fault_code held; exit only via reset.
- Reset mid-operation (any state, including MEM with memwrite=1) immediately drops all outputs to 0 and returns to FETCH. No partial write is retried.
- Opcode is sampled combinationally from ir_opcode; the datapath holds the IR stable from DECODE until the next ir_write.

Decomposition:
- Package legv8_ctrl_pkg:
  - opcode casez constants for all eleven instructions;
  - ALUOP_* and SIGNOP_* localparams;
  - state enum;
  - instruction-class enum (RTYPE, ITYPE, MOVZ, B, CBZ, LDUR, STUR, ILLEGAL);
  - FAULT_* codes.
- Sub-module opcode_classify: combinational ir_opcode → class plus static aluop/signop, shared with any future pipelined decoder.

Test Plan:
- ADD opcode 10001011000, both readies tied 1 → exactly 4 cycles FETCH→WB; aluop=0010 in EXEC and WB; regwrite=1 only in WB; one instr_done; pc_src=0.
- CBZ 10110100000 with alu_zero=1, then with alu_zero=0 → each 3 cycles; pc_src=1, then 0; branch=1 in EXEC only; regwrite never 1.
- LDUR 11111000010 with dmem_ready delayed 3 cycles → MEM lasts 4 cycles with memread=1 throughout; WB has mem2reg=1, regwrite=1; total 8 cycles.
- Illegal opcode 00000000000 → HALT after DECODE; halted=1, fault_code=01; no pc_write; stays halted for 100 cycles until resetl pulse.
- imem_ready held 0 with WAIT_LIMIT=4 → HALT with fault_code=10 after 5 FETCH cycles; imem_ready rising on the 5th cycle instead → no fault.
- STUR 11111000000 with resetl asserted in MEM while memwrite=1 → memwrite drops asynchronously that cycle; after release state=FETCH, imem_req=1.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multicycle controller: opcodes, ALU/sign-extend
// selects, FSM state codes, instruction classes and fault codes.
package legv8_ctrl_pkg;

   // Opcode patterns on instruction[31:21]; '?' bits are don't-care in casez.
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_ADDI = 11'b1001000100?;
   localparam logic [10:0] OP_SUBI = 11'b1101000100?;
   localparam logic [10:0] OP_MOVZ = 11'b110100101??;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_B    = 11'b000101?????;
   localparam logic [10:0] OP_CBZ  = 11'b10110100???;

   localparam logic [3:0] ALUOP_AND   = 4'b0000;
   localparam logic [3:0] ALUOP_ORR   = 4'b0001;
   localparam logic [3:0] ALUOP_ADD   = 4'b0010;
   localparam logic [3:0] ALUOP_SUB   = 4'b0110;
   localparam logic [3:0] ALUOP_PASSB = 4'b0111;
   localparam logic [3:0] ALUOP_MOVZ  = 4'b1000;

   localparam logic [1:0] SIGNOP_I  = 2'b00;
   localparam logic [1:0] SIGNOP_CB = 2'b01;
   localparam logic [1:0] SIGNOP_B  = 2'b10;
   localparam logic [1:0] SIGNOP_D  = 2'b11;

   typedef logic [2:0] state_t;
   localparam state_t StFetch  = 3'd0;
   localparam state_t StDecode = 3'd1;
   localparam state_t StExec   = 3'd2;
   localparam state_t StMem    = 3'd3;
   localparam state_t StWb     = 3'd4;
   localparam state_t StHalt   = 3'd5;

   typedef enum logic [2:0] {
      ClsRtype,
      ClsItype,
      ClsMovz,
      ClsB,
      ClsCbz,
      ClsLdur,
      ClsStur,
      ClsIllegal
   } instr_class_e;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_IMEM    = 2'b10;
   localparam logic [1:0] FAULT_DMEM    = 2'b11;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: instruction class plus the static ALU operation
// and sign-extend mode for that instruction.
module opcode_classify
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0]  ir_opcode_i,
   output instr_class_e cls_o,
   output logic [3:0]   aluop_o,
   output logic [1:0]   signop_o
);

   always_comb begin
      cls_o    = ClsIllegal;
      aluop_o  = 4'b0000;
      signop_o = 2'b00;
      casez (ir_opcode_i)
         OP_ADD:  begin cls_o = ClsRtype; aluop_o = ALUOP_ADD; end
         OP_SUB:  begin cls_o = ClsRtype; aluop_o = ALUOP_SUB; end
         OP_AND:  begin cls_o = ClsRtype; aluop_o = ALUOP_AND; end
         OP_ORR:  begin cls_o = ClsRtype; aluop_o = ALUOP_ORR; end
         OP_ADDI: begin cls_o = ClsItype; aluop_o = ALUOP_ADD; signop_o = SIGNOP_I; end
         OP_SUBI: begin cls_o = ClsItype; aluop_o = ALUOP_SUB; signop_o = SIGNOP_I; end
         OP_MOVZ: begin cls_o = ClsMovz;  aluop_o = ALUOP_MOVZ; signop_o = SIGNOP_I; end
         OP_LDUR: begin cls_o = ClsLdur;  aluop_o = ALUOP_ADD; signop_o = SIGNOP_D; end
         OP_STUR: begin cls_o = ClsStur;  aluop_o = ALUOP_ADD; signop_o = SIGNOP_D; end
         OP_B:    begin cls_o = ClsB;     signop_o = SIGNOP_B; end
         OP_CBZ:  begin cls_o = ClsCbz;   aluop_o = ALUOP_PASSB; signop_o = SIGNOP_CB; end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Per-phase LEGv8 control FSM with variable-latency memory handshakes, a bounded
// wait counter and a sticky halt on illegal opcode or memory timeout.
module multicycle_control
   import legv8_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 8
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [10:0] ir_opcode,
   input  logic        alu_zero,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg2loc,
   output logic        alusrc,
   output logic        mem2reg,
   output logic        regwrite,
   output logic        memread,
   output logic        memwrite,
   output logic        branch,
   output logic        uncond_branch,
   output logic [3:0]  aluop,
   output logic [1:0]  signop,
   output logic        instr_done,
   output logic        halted,
   output logic [1:0]  fault_code
);

   localparam logic [CNT_W-1:0] Limit = CNT_W'(WAIT_LIMIT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       fault_q, fault_d;

   instr_class_e cls;
   logic [3:0]   cls_aluop;
   logic [1:0]   cls_signop;
   logic         wait_expired;
   logic         exec_reg2loc;
   logic         exec_alusrc;

   opcode_classify u_classify (
      .ir_opcode_i (ir_opcode),
      .cls_o       (cls),
      .aluop_o     (cls_aluop),
      .signop_o    (cls_signop)
   );

   assign wait_expired = (WAIT_LIMIT != 0) && (cnt_q == Limit);
   assign exec_reg2loc = cls inside {ClsCbz, ClsStur};
   assign exec_alusrc  = cls inside {ClsItype, ClsMovz, ClsLdur, ClsStur};

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      unique case (state_q)
         StFetch: begin
            if (imem_ready) begin
               state_d = StDecode;
            end else if (wait_expired) begin
               state_d = StHalt;
               fault_d = FAULT_IMEM;
            end
         end
         StDecode: begin
            if (cls == ClsIllegal) begin
               state_d = StHalt;
               fault_d = FAULT_ILLEGAL;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            unique case (cls)
               ClsB, ClsCbz:                state_d = StFetch;
               ClsLdur, ClsStur:            state_d = StMem;
               ClsRtype, ClsItype, ClsMovz: state_d = StWb;
               default: begin
                  state_d = StHalt;
                  fault_d = FAULT_ILLEGAL;
               end
            endcase
         end
         StMem: begin
            if (dmem_ready) begin
               state_d = (cls == ClsLdur) ? StWb : StFetch;
            end else if (wait_expired) begin
               state_d = StHalt;
               fault_d = FAULT_DMEM;
            end
         end
         StWb:    state_d = StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   // Counter only advances while waiting on a memory; any transition restarts it.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q == StFetch || state_q == StMem) && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= StFetch;
         cnt_q   <= '0;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Outputs are gated by resetl so an asserted reset silences the datapath at once.
   always_comb begin
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      reg2loc       = 1'b0;
      alusrc        = 1'b0;
      mem2reg       = 1'b0;
      regwrite      = 1'b0;
      memread       = 1'b0;
      memwrite      = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b0;
      aluop         = 4'b0000;
      signop        = 2'b00;
      instr_done    = 1'b0;
      halted        = 1'b0;
      fault_code    = FAULT_NONE;
      if (resetl) begin
         fault_code = fault_q;
         unique case (state_q)
            StFetch: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
            end
            StExec: begin
               reg2loc = exec_reg2loc;
               alusrc  = exec_alusrc;
               aluop   = cls_aluop;
               signop  = cls_signop;
               if (cls == ClsB) begin
                  uncond_branch = 1'b1;
                  pc_src        = 1'b1;
                  pc_write      = 1'b1;
                  instr_done    = 1'b1;
               end else if (cls == ClsCbz) begin
                  branch     = 1'b1;
                  pc_src     = alu_zero;
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
               end
            end
            StMem: begin
               alusrc   = 1'b1;
               aluop    = ALUOP_ADD;
               signop   = SIGNOP_D;
               reg2loc  = (cls == ClsStur);
               memread  = (cls == ClsLdur);
               memwrite = (cls == ClsStur);
               if (cls == ClsStur && dmem_ready) begin
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
               end
            end
            StWb: begin
               reg2loc    = exec_reg2loc;
               alusrc     = exec_alusrc;
               aluop      = cls_aluop;
               signop     = cls_signop;
               regwrite   = 1'b1;
               mem2reg    = (cls == ClsLdur);
               pc_write   = 1'b1;
               instr_done = 1'b1;
            end
            StHalt:  halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table plus hand-written
// sequences for illegal-opcode halt and reset during a store.
module tb_multicycle_control;

   logic        CLK = 1'b0;
   logic        resetl = 1'b0;
   logic [10:0] ir_opcode = '0;
   logic        alu_zero = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, regwrite;
   logic        memread, memwrite, branch, uncond_branch, instr_done, halted;
   logic [3:0]  aluop;
   logic [1:0]  signop, fault_code;

   always #5 CLK = ~CLK;

   multicycle_control #(
      .WAIT_LIMIT (4),
      .CNT_W      (8)
   ) dut (
      .CLK           (CLK),
      .resetl        (resetl),
      .ir_opcode     (ir_opcode),
      .alu_zero      (alu_zero),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .imem_req      (imem_req),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .reg2loc       (reg2loc),
      .alusrc        (alusrc),
      .mem2reg       (mem2reg),
      .regwrite      (regwrite),
      .memread       (memread),
      .memwrite      (memwrite),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .aluop         (aluop),
      .signop        (signop),
      .instr_done    (instr_done),
      .halted        (halted),
      .fault_code    (fault_code)
   );

   // Control bit positions inside the 12-bit control group of a vector.
   localparam logic [11:0] IMQ = 12'h800, IRW = 12'h400, PCW = 12'h200, PCS = 12'h100;
   localparam logic [11:0] R2L = 12'h080, ASR = 12'h040, M2R = 12'h020, RGW = 12'h010;
   localparam logic [11:0] MRD = 12'h008, MWR = 12'h004, BRN = 12'h002, UNB = 12'h001;

   localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000;
   localparam logic [10:0] AND = 11'b10001010000, ORR = 11'b10101010000;
   localparam logic [10:0] ADDI = 11'b10010001000, MOVZ = 11'b11010010100;
   localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;
   localparam logic [10:0] BR = 11'b00010100000, CBZ = 11'b10110100000;
   localparam logic [10:0] ILL = 11'b00000000000;

   logic [21:0] act;
   assign act = {imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, regwrite,
                 memread, memwrite, branch, uncond_branch, aluop, signop, instr_done,
                 halted, fault_code};

   typedef struct {
      logic        rst;
      logic [10:0] op;
      logic        z;
      logic        ir;
      logic        dr;
      logic [21:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic logic [21:0] ex(input logic [11:0] c, input logic [3:0] a,
                                      input logic [1:0] s, input logic d);
      return {c, a, s, d, 1'b0, 2'b00};
   endfunction

   function automatic logic [21:0] hlt(input logic [1:0] f);
      return {12'd0, 4'd0, 2'd0, 1'b0, 1'b1, f};
   endfunction

   task automatic push(input logic rst, input logic [10:0] op, input logic z, input logic ir,
                       input logic dr, input logic [21:0] exp);
      vecs.push_back('{rst, op, z, ir, dr, exp});
   endtask

   task automatic check(input string name, input logic [21:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive inputs just after a rising edge, compare on the falling edge.
   task automatic run(input string name, input logic [10:0] op, input logic z, input logic ir,
                      input logic dr, input logic [21:0] exp);
      ir_opcode  = op;
      alu_zero   = z;
      imem_ready = ir;
      dmem_ready = dr;
      @(negedge CLK);
      check(name, exp);
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      resetl = 1'b0;
      #1;
      check("reset_outputs", '0);
      @(posedge CLK);
      #1;
      resetl = 1'b1;
   endtask

   task automatic fetch_decode(input logic [10:0] op);
      push(1'b0, op, 1'b0, 1'b1, 1'b1, ex(IMQ | IRW, 4'b0000, 2'b00, 1'b0));
      push(1'b0, op, 1'b0, 1'b1, 1'b1, '0);
   endtask

   initial begin
      // ADD, zero-wait: 4 cycles
      push(1'b1, ADD, 1'b0, 1'b1, 1'b1, ex(IMQ | IRW, 4'b0000, 2'b00, 1'b0));
      push(1'b0, ADD, 1'b0, 1'b1, 1'b1, '0);
      push(1'b0, ADD, 1'b0, 1'b1, 1'b1, ex('0, 4'b0010, 2'b00, 1'b0));
      push(1'b0, ADD, 1'b0, 1'b1, 1'b1, ex(RGW | PCW, 4'b0010, 2'b00, 1'b1));
      // CBZ taken, then not taken
      fetch_decode(CBZ);
      push(1'b0, CBZ, 1'b1, 1'b1, 1'b1, ex(BRN | R2L | PCW | PCS, 4'b0111, 2'b01, 1'b1));
      fetch_decode(CBZ);
      push(1'b0, CBZ, 1'b0, 1'b1, 1'b1, ex(BRN | R2L | PCW, 4'b0111, 2'b01, 1'b1));
      // B
      fetch_decode(BR);
      push(1'b0, BR, 1'b0, 1'b1, 1'b1, ex(UNB | PCS | PCW, 4'b0000, 2'b10, 1'b1));
      // LDUR with dmem ready on the 4th MEM cycle
      fetch_decode(LDUR);
      push(1'b0, LDUR, 1'b0, 1'b1, 1'b0, ex(ASR, 4'b0010, 2'b11, 1'b0));
      for (int i = 0; i < 3; i++)
         push(1'b0, LDUR, 1'b0, 1'b1, 1'b0, ex(ASR | MRD, 4'b0010, 2'b11, 1'b0));
      push(1'b0, LDUR, 1'b0, 1'b1, 1'b1, ex(ASR | MRD, 4'b0010, 2'b11, 1'b0));
      push(1'b0, LDUR, 1'b0, 1'b1, 1'b1, ex(ASR | M2R | RGW | PCW, 4'b0010, 2'b11, 1'b1));
      // STUR zero-wait
      fetch_decode(STUR);
      push(1'b0, STUR, 1'b0, 1'b1, 1'b1, ex(ASR | R2L, 4'b0010, 2'b11, 1'b0));
      push(1'b0, STUR, 1'b0, 1'b1, 1'b1, ex(ASR | R2L | MWR | PCW, 4'b0010, 2'b11, 1'b1));
      // imem ready arrives exactly at the wait limit: no fault, then SUB
      for (int i = 0; i < 4; i++)
         push(1'b0, SUB, 1'b0, 1'b0, 1'b1, ex(IMQ, 4'b0000, 2'b00, 1'b0));
      fetch_decode(SUB);
      push(1'b0, SUB, 1'b0, 1'b1, 1'b1, ex('0, 4'b0110, 2'b00, 1'b0));
      push(1'b0, SUB, 1'b0, 1'b1, 1'b1, ex(RGW | PCW, 4'b0110, 2'b00, 1'b1));
      fetch_decode(ORR);
      push(1'b0, ORR, 1'b0, 1'b1, 1'b1, ex('0, 4'b0001, 2'b00, 1'b0));
      push(1'b0, ORR, 1'b0, 1'b1, 1'b1, ex(RGW | PCW, 4'b0001, 2'b00, 1'b1));
      fetch_decode(AND);
      push(1'b0, AND, 1'b0, 1'b1, 1'b1, ex('0, 4'b0000, 2'b00, 1'b0));
      push(1'b0, AND, 1'b0, 1'b1, 1'b1, ex(RGW | PCW, 4'b0000, 2'b00, 1'b1));
      fetch_decode(ADDI);
      push(1'b0, ADDI, 1'b0, 1'b1, 1'b1, ex(ASR, 4'b0010, 2'b00, 1'b0));
      push(1'b0, ADDI, 1'b0, 1'b1, 1'b1, ex(ASR | RGW | PCW, 4'b0010, 2'b00, 1'b1));
      fetch_decode(MOVZ);
      push(1'b0, MOVZ, 1'b0, 1'b1, 1'b1, ex(ASR, 4'b1000, 2'b00, 1'b0));
      push(1'b0, MOVZ, 1'b0, 1'b1, 1'b1, ex(ASR | RGW | PCW, 4'b1000, 2'b00, 1'b1));
      // imem timeout: 5 FETCH cycles then HALT with fault 10
      for (int i = 0; i < 5; i++)
         push(1'b0, ADD, 1'b0, 1'b0, 1'b0, ex(IMQ, 4'b0000, 2'b00, 1'b0));
      push(1'b0, ADD, 1'b0, 1'b1, 1'b1, hlt(2'b10));
      push(1'b0, ADD, 1'b0, 1'b1, 1'b1, hlt(2'b10));
      // dmem timeout after reset: 5 MEM cycles then HALT with fault 11
      push(1'b1, LDUR, 1'b0, 1'b1, 1'b0, ex(IMQ | IRW, 4'b0000, 2'b00, 1'b0));
      push(1'b0, LDUR, 1'b0, 1'b1, 1'b0, '0);
      push(1'b0, LDUR, 1'b0, 1'b1, 1'b0, ex(ASR, 4'b0010, 2'b11, 1'b0));
      for (int i = 0; i < 5; i++)
         push(1'b0, LDUR, 1'b0, 1'b1, 1'b0, ex(ASR | MRD, 4'b0010, 2'b11, 1'b0));
      push(1'b0, LDUR, 1'b0, 1'b1, 1'b1, hlt(2'b11));

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         run($sformatf("vec%0d", i), vecs[i].op, vecs[i].z, vecs[i].ir, vecs[i].dr,
             vecs[i].exp);
      end

      // Illegal opcode halts after DECODE and stays halted until reset
      do_reset();
      run("ill_fetch", ILL, 1'b0, 1'b1, 1'b1, ex(IMQ | IRW, 4'b0000, 2'b00, 1'b0));
      run("ill_decode", ILL, 1'b0, 1'b1, 1'b1, '0);
      for (int i = 0; i < 100; i++)
         run($sformatf("ill_halt%0d", i), ADD, 1'b1, 1'b1, 1'b1, hlt(2'b01));
      do_reset();
      run("ill_after_reset", ADD, 1'b0, 1'b0, 1'b0, ex(IMQ, 4'b0000, 2'b00, 1'b0));

      // Reset asserted mid-MEM of a store drops memwrite immediately
      do_reset();
      run("st_fetch", STUR, 1'b0, 1'b1, 1'b0, ex(IMQ | IRW, 4'b0000, 2'b00, 1'b0));
      run("st_decode", STUR, 1'b0, 1'b1, 1'b0, '0);
      run("st_exec", STUR, 1'b0, 1'b1, 1'b0, ex(ASR | R2L, 4'b0010, 2'b11, 1'b0));
      @(negedge CLK);
      check("st_mem", ex(ASR | R2L | MWR, 4'b0010, 2'b11, 1'b0));
      #1;
      resetl = 1'b0;
      #1;
      check("st_mem_reset", '0);
      @(posedge CLK);
      #1;
      resetl = 1'b1;
      run("st_after_reset", STUR, 1'b0, 1'b0, 1'b0, ex(IMQ, 4'b0000, 2'b00, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
